// File: rtl/cct_exerciser_pkg.sv
// Shared types and the Q4 golden model for the midterm circuit exerciser.
// The testbench can import the same golden function the checker uses.
package cct_exerciser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Selector is {v[0], v[1]}: bit 0 of the vector is the selector MSB.
    localparam logic [1:0] SEL_PASS_V2  = 2'b00;
    localparam logic [1:0] SEL_XOR_45   = 2'b10;
    localparam logic [1:0] SEL_NOR_45_3 = 2'b01;
    localparam logic [1:0] SEL_XNOR_67  = 2'b11;

    localparam logic [8:0] ERR_MAX = 9'd256;

    function automatic logic [7:0] cct_q4_expected(input logic [7:0] v);
        logic [1:0] sel;
        logic       f;
        sel = {v[0], v[1]};
        f   = 1'b0;
        case (sel)
            SEL_PASS_V2:  f = v[2];
            SEL_XOR_45:   f = v[4] ^ v[5];
            SEL_NOR_45_3: f = ~((v[4] ^ v[5]) | v[3]);
            SEL_XNOR_67:  f = ~(v[6] ^ v[7]);
            default:      f = 1'b0;
        endcase
        return {1'b0, f, 6'b000000};
    endfunction

endpackage

// File: rtl/cct_exerciser_q4_golden.sv
// Combinational golden model instance, kept as its own module so the
// expected response of the current vector is visible as a named net.
module cct_q4_golden
    import cct_exerciser_pkg::*;
(
    input  logic [7:0] v_i,
    output logic [7:0] exp_o
);

    assign exp_o = cct_q4_expected(v_i);

endmodule

// File: rtl/cct_exerciser.sv
// Sweeps a vector range into the student circuit, holds each vector for
// SETTLE cycles, compares the response with the golden model and logs errors.
module cct_exerciser
    import cct_exerciser_pkg::*;
#(
    parameter logic [7:0]  START_VEC = 8'h00,
    parameter logic [7:0]  LAST_VEC  = 8'hFF,
    parameter int unsigned SETTLE    = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] stim,
    input  logic [7:0] resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic [7:0] first_fail_vec,
    output logic [7:0] first_fail_resp,
    output logic       fail_seen
);

    if (START_VEC > LAST_VEC) begin : g_bad_range
        $error("cct_exerciser: START_VEC must not exceed LAST_VEC");
    end
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("cct_exerciser: SETTLE must be in 1..15");
    end

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE - 1);

    state_e     state_q;
    logic [7:0] stim_q;
    logic [3:0] cnt_q;
    logic [8:0] err_q;
    logic [7:0] ffv_q;
    logic [7:0] ffr_q;
    logic       fs_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic [7:0] exp_w;
    logic       mismatch;
    logic [8:0] err_d;

    cct_q4_golden u_golden (
        .v_i   (stim_q),
        .exp_o (exp_w)
    );

    // Error count as it will stand after this CHECK cycle; pass is judged on it.
    assign mismatch = (resp != exp_w);
    assign err_d    = (mismatch && err_q != ERR_MAX) ? err_q + 9'd1 : err_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            stim_q  <= 8'h00;
            cnt_q   <= 4'd0;
            err_q   <= 9'd0;
            ffv_q   <= 8'h00;
            ffr_q   <= 8'h00;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        stim_q  <= START_VEC;
                        cnt_q   <= SETTLE_RELOAD;
                        err_q   <= 9'd0;
                        fs_q    <= 1'b0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        err_q <= err_d;
                        if (mismatch && !fs_q) begin
                            ffv_q <= stim_q;
                            ffr_q <= resp;
                            fs_q  <= 1'b1;
                        end
                        // Last-vector test comes first so stim never wraps.
                        if (stim_q == LAST_VEC) begin
                            pass_q  <= (err_d == 9'd0);
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            stim_q  <= stim_q + 8'd1;
                            cnt_q   <= SETTLE_RELOAD;
                            state_q <= DRIVE;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stim            = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_resp = ffr_q;
    assign fail_seen       = fs_q;

endmodule

// File: tb/tb_cct_exerciser.sv
// Bench for cct_exerciser: a full-range instance and a narrow-range instance,
// responders built from an independent model plus per-vector fault masks.
module tb_cct_exerciser;

    localparam int CAP = 2000;

    logic       clk;
    logic       clear;

    logic       start_a, abort_a, busy_a, done_a, pass_a, fs_a;
    logic [7:0] stim_a, resp_a, ffv_a, ffr_a;
    logic [8:0] err_a;
    logic [7:0] mask_a [256];

    logic       start_b, abort_b, busy_b, done_b, pass_b, fs_b;
    logic [7:0] stim_b, resp_b, ffv_b, ffr_b;
    logic [8:0] err_b;

    int total;
    int bad;

    typedef struct {
        string      name;
        int         kind;
        logic [8:0] exp_err;
        logic [7:0] exp_fvec;
        logic [7:0] exp_fresp;
        logic       exp_pass;
        logic       exp_fs;
    } run_vec_t;

    typedef struct {
        logic [7:0] v;
        logic [7:0] exp;
    } gold_vec_t;

    // Independent statement of the Q4 rules: selector value = 2*v[0] + v[1].
    function automatic logic [7:0] model_exp(input logic [7:0] v);
        int sel;
        int f;
        sel = 2 * int'(v[0]) + int'(v[1]);
        case (sel)
            0:       f = int'(v[2]);
            2:       f = (int'(v[4]) + int'(v[5])) % 2;
            1:       f = (v[4] == v[5] && v[3] == 1'b0) ? 1 : 0;
            default: f = (v[6] == v[7]) ? 1 : 0;
        endcase
        return (f != 0) ? 8'h40 : 8'h00;
    endfunction

    assign resp_a = model_exp(stim_a) ^ mask_a[stim_a];
    assign resp_b = model_exp(stim_b);

    cct_exerciser u_full (
        .clk             (clk),
        .clear           (clear),
        .start           (start_a),
        .abort           (abort_a),
        .stim            (stim_a),
        .resp            (resp_a),
        .busy            (busy_a),
        .done            (done_a),
        .pass            (pass_a),
        .err_count       (err_a),
        .first_fail_vec  (ffv_a),
        .first_fail_resp (ffr_a),
        .fail_seen       (fs_a)
    );

    cct_exerciser #(
        .START_VEC (8'h02),
        .LAST_VEC  (8'h04),
        .SETTLE    (2)
    ) u_rng (
        .clk             (clk),
        .clear           (clear),
        .start           (start_b),
        .abort           (abort_b),
        .stim            (stim_b),
        .resp            (resp_b),
        .busy            (busy_b),
        .done            (done_b),
        .pass            (pass_b),
        .err_count       (err_b),
        .first_fail_vec  (ffv_b),
        .first_fail_resp (ffr_b),
        .fail_seen       (fs_b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_mask(input int kind);
        for (int v = 0; v < 256; v++) begin
            case (kind)
                1:       mask_a[v] = (v == 0) ? 8'h40 : 8'h00;
                2:       mask_a[v] = model_exp(8'(v));
                3:       mask_a[v] = model_exp(8'(v)) ^ 8'hFF;
                4:       mask_a[v] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                default: mask_a[v] = 8'h00;
            endcase
        end
    endtask

    // Pulses start on the full-range DUT and returns the cycle index of done.
    task automatic run_a(input int abort_at, input int extra_start_at, output int cycles);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        cycles  = 1;
        chk("busy_in_run", busy_a, 1'b1);
        while (!done_a && cycles < CAP) begin
            if (cycles == abort_at) abort_a = 1'b1;
            if (cycles == extra_start_at) start_a = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
            abort_a = 1'b0;
            start_a = 1'b0;
        end
        if (!done_a) chk("run_timeout", 32'(cycles), 32'(CAP + 1));
    endtask

    task automatic check_result(input string tag, input logic [8:0] e_err, input logic [7:0] e_fv,
                                input logic [7:0] e_fr, input logic e_pass, input logic e_fs);
        chk({tag, "_err"}, err_a, e_err);
        chk({tag, "_pass"}, pass_a, e_pass);
        chk({tag, "_fs"}, fs_a, e_fs);
        chk({tag, "_busy"}, busy_a, 1'b0);
        if (e_fs) begin
            chk({tag, "_ffv"}, ffv_a, e_fv);
            chk({tag, "_ffr"}, ffr_a, e_fr);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, done_a, 1'b0);
    endtask

    initial begin
        run_vec_t   runs [4];
        gold_vec_t  gold [10];
        int         cyc;
        logic [8:0] m_err;
        logic [7:0] m_fv, m_fr;
        logic       m_fs;
        logic [7:0] walk [3];

        total   = 0;
        bad     = 0;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        set_mask(0);

        runs[0] = '{"ideal",     0, 9'd0,   8'h00, 8'h00, 1'b1, 1'b0};
        runs[1] = '{"single",    1, 9'd1,   8'h00, 8'h40, 1'b0, 1'b1};
        runs[2] = '{"stuck0",    2, 9'd112, 8'h02, 8'h00, 1'b0, 1'b1};
        runs[3] = '{"all_wrong", 3, 9'd256, 8'h00, 8'hFF, 1'b0, 1'b1};

        gold[0] = '{8'h00, 8'h00};
        gold[1] = '{8'h01, 8'h00};
        gold[2] = '{8'h02, 8'h40};
        gold[3] = '{8'h03, 8'h40};
        gold[4] = '{8'h04, 8'h40};
        gold[5] = '{8'h11, 8'h40};
        gold[6] = '{8'h12, 8'h00};
        gold[7] = '{8'h0A, 8'h00};
        gold[8] = '{8'h83, 8'h00};
        gold[9] = '{8'hC3, 8'h40};

        clear = 1'b0;
        #23;
        chk("rst_stim", stim_a, 8'h00);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_pass", pass_a, 1'b0);
        chk("rst_err", err_a, 9'd0);
        chk("rst_fs", fs_a, 1'b0);
        chk("rst_stim_b", stim_b, 8'h00);
        @(negedge clk);
        clear = 1'b1;

        for (int i = 0; i < 10; i++) begin
            chk("gold_model", model_exp(gold[i].v), gold[i].exp);
            chk("gold_pkg", cct_exerciser_pkg::cct_q4_expected(gold[i].v), gold[i].exp);
        end
        for (int v = 0; v < 256; v++) begin
            chk("gold_sweep", cct_exerciser_pkg::cct_q4_expected(8'(v)), model_exp(8'(v)));
        end

        for (int r = 0; r < 4; r++) begin
            set_mask(runs[r].kind);
            run_a(-1, -1, cyc);
            chk({runs[r].name, "_len"}, 32'(cyc), 32'd769);
            check_result(runs[r].name, runs[r].exp_err, runs[r].exp_fvec,
                         runs[r].exp_fresp, runs[r].exp_pass, runs[r].exp_fs);
        end

        for (int r = 0; r < 3; r++) begin
            set_mask(4);
            m_err = 9'd0;
            m_fs  = 1'b0;
            m_fv  = 8'h00;
            m_fr  = 8'h00;
            for (int v = 0; v < 256; v++) begin
                if (mask_a[v] != 8'h00) begin
                    m_err++;
                    if (!m_fs) begin
                        m_fs = 1'b1;
                        m_fv = 8'(v);
                        m_fr = model_exp(8'(v)) ^ mask_a[v];
                    end
                end
            end
            run_a(-1, -1, cyc);
            chk("rand_len", 32'(cyc), 32'd769);
            check_result("rand", m_err, m_fv, m_fr, (m_err == 9'd0), m_fs);
        end

        // Abort keeps partial error data, then a fresh run is clean.
        set_mask(1);
        run_a(100, -1, cyc);
        chk("abort_len", 32'(cyc), 32'd101);
        chk("abort_done", done_a, 1'b1);
        check_result("abort", 9'd1, 8'h00, 8'h40, 1'b0, 1'b1);
        set_mask(0);
        run_a(-1, -1, cyc);
        chk("restart_len", 32'(cyc), 32'd769);
        check_result("restart", 9'd0, 8'h00, 8'h00, 1'b1, 1'b0);

        run_a(-1, 50, cyc);
        chk("start_busy_len", 32'(cyc), 32'd769);
        check_result("start_busy", 9'd0, 8'h00, 8'h00, 1'b1, 1'b0);

        @(negedge clk);
        start_a = 1'b1;
        abort_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("start_abort_busy", busy_a, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("start_abort_idle", busy_a, 1'b0);

        // Narrow range instance: vector walk and run length.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        cyc = 1;
        while (!done_b && cyc < CAP) begin
            if (cyc == 1) walk[0] = stim_b;
            if (cyc == 4) walk[1] = stim_b;
            if (cyc == 7) walk[2] = stim_b;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rng_len", 32'(cyc), 32'd10);
        chk("rng_pass", pass_b, 1'b1);
        chk("rng_err", err_b, 9'd0);
        for (int i = 0; i < 3; i++) chk("rng_walk", walk[i], 8'(i + 2));
        repeat (4) @(posedge clk);
        #1;
        chk("rng_stim_hold", stim_b, 8'h04);

        // Asynchronous clear in the middle of a failing run.
        set_mask(2);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("pre_clear_fs", fs_a, 1'b1);
        #2;
        clear = 1'b0;
        #1;
        chk("clr_stim", stim_a, 8'h00);
        chk("clr_busy", busy_a, 1'b0);
        chk("clr_err", err_a, 9'd0);
        chk("clr_fs", fs_a, 1'b0);
        chk("clr_ffv", ffv_a, 8'h00);
        m_fs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done_a) m_fs = 1'b1;
        end
        chk("clr_no_done", m_fs, 1'b0);
        @(negedge clk);
        clear = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
